// File: rtl/ysyx_20020207_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter.
// One transaction in flight; round-robin grant registered out of IDLE.
module ysyx_20020207_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ifu_arvalid,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_rready,
  output logic                ifu_arready,
  output logic                ifu_rvalid,
  output logic [1:0]          ifu_rresp,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_arvalid,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_rready,
  output logic                lsu_arready,
  output logic                lsu_rvalid,
  output logic [1:0]          lsu_rresp,
  output logic [DATA_W-1:0]   lsu_rdata,
  input  logic                lsu_awvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_wvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_bready,
  output logic                lsu_awready,
  output logic                lsu_wready,
  output logic                lsu_bvalid,
  output logic [1:0]          lsu_bresp,
  output logic                arvalid,
  output logic [ADDR_W-1:0]   araddr,
  output logic                rready,
  output logic                awvalid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                wvalid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                bready,
  input  logic                arready,
  input  logic                rvalid,
  input  logic [1:0]          rresp,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                awready,
  input  logic                wready,
  input  logic                bvalid,
  input  logic [1:0]          bresp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   last_lsu, last_lsu_nxt;
  logic   ar_done, ar_done_nxt;
  logic   aw_done, aw_done_nxt;
  logic   w_done, w_done_nxt;
  logic   ifu_req, lsu_req;
  logic   ar_fire, r_fire;
  logic   aw_fire, w_fire, b_fire;

  assign ifu_req = ifu_arvalid;
  assign lsu_req = lsu_arvalid | lsu_awvalid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last_lsu <= 1'b0;
      ar_done  <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_lsu <= last_lsu_nxt;
      ar_done  <= ar_done_nxt;
      aw_done  <= aw_done_nxt;
      w_done   <= w_done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_lsu_nxt = last_lsu;
    ar_done_nxt  = ar_done;
    aw_done_nxt  = aw_done;
    w_done_nxt   = w_done;
    arvalid      = 1'b0;
    araddr       = '0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    awaddr       = '0;
    wvalid       = 1'b0;
    wdata        = '0;
    wstrb        = '0;
    bready       = 1'b0;
    ifu_arready  = 1'b0;
    ifu_rvalid   = 1'b0;
    ifu_rresp    = '0;
    ifu_rdata    = '0;
    lsu_arready  = 1'b0;
    lsu_rvalid   = 1'b0;
    lsu_rresp    = '0;
    lsu_rdata    = '0;
    lsu_awready  = 1'b0;
    lsu_wready   = 1'b0;
    lsu_bvalid   = 1'b0;
    lsu_bresp    = '0;
    ar_fire      = 1'b0;
    r_fire       = 1'b0;
    aw_fire      = 1'b0;
    w_fire       = 1'b0;
    b_fire       = 1'b0;
    unique case (state)
      IDLE: begin
        // On contention, LSU wins unless it owned the previous slot
        if (lsu_req && (!ifu_req || !last_lsu))
          state_nxt = lsu_awvalid ? LSU_WR : LSU_RD;
        else if (ifu_req)
          state_nxt = IFU_RD;
      end
      IFU_RD: begin
        arvalid     = ifu_arvalid & ~ar_done;
        araddr      = ifu_araddr;
        ifu_arready = arready & ~ar_done;
        rready      = ifu_rready;
        ifu_rvalid  = rvalid;
        ifu_rresp   = rresp;
        ifu_rdata   = rdata;
        ar_fire     = ifu_arvalid & ~ar_done & arready;
        r_fire      = rvalid & ifu_rready;
      end
      LSU_RD: begin
        arvalid     = lsu_arvalid & ~ar_done;
        araddr      = lsu_araddr;
        lsu_arready = arready & ~ar_done;
        rready      = lsu_rready;
        lsu_rvalid  = rvalid;
        lsu_rresp   = rresp;
        lsu_rdata   = rdata;
        ar_fire     = lsu_arvalid & ~ar_done & arready;
        r_fire      = rvalid & lsu_rready;
      end
      LSU_WR: begin
        awvalid     = lsu_awvalid & ~aw_done;
        awaddr      = lsu_awaddr;
        lsu_awready = awready & ~aw_done;
        wvalid      = lsu_wvalid & ~w_done;
        wdata       = lsu_wdata;
        wstrb       = lsu_wstrb;
        lsu_wready  = wready & ~w_done;
        bready      = lsu_bready;
        lsu_bvalid  = bvalid;
        lsu_bresp   = bresp;
        aw_fire     = lsu_awvalid & ~aw_done & awready;
        w_fire      = lsu_wvalid & ~w_done & wready;
        b_fire      = bvalid & lsu_bready;
      end
      default: state_nxt = IDLE;
    endcase
    if (ar_fire) ar_done_nxt = 1'b1;
    if (aw_fire) aw_done_nxt = 1'b1;
    if (w_fire)  w_done_nxt  = 1'b1;
    // Response beat closes the transaction, even in the address-accept cycle
    if (r_fire) begin
      state_nxt    = IDLE;
      ar_done_nxt  = 1'b0;
      last_lsu_nxt = (state == LSU_RD);
    end
    if (b_fire) begin
      state_nxt    = IDLE;
      aw_done_nxt  = 1'b0;
      w_done_nxt   = 1'b0;
      last_lsu_nxt = 1'b1;
    end
  end

endmodule
